// File: rtl/riscv_soft_imm_stage_pkg.sv
// Shared immediate-select encodings for the immediate stage.
// Imported by the extractor and the stage top.
package riscv_soft_imm_stage_pkg;

    localparam int IMM_SEL_W = 3;

    localparam logic [IMM_SEL_W-1:0] IMM_I = 3'd0;
    localparam logic [IMM_SEL_W-1:0] IMM_S = 3'd1;
    localparam logic [IMM_SEL_W-1:0] IMM_B = 3'd2;
    localparam logic [IMM_SEL_W-1:0] IMM_U = 3'd3;
    localparam logic [IMM_SEL_W-1:0] IMM_J = 3'd4;
    localparam logic [IMM_SEL_W-1:0] IMM_Z = 3'd5;

endpackage

// File: rtl/riscv_soft_imm_extract.sv
// Combinational immediate extraction for I/S/B/U/J and CSR zimm.
// All types are built as a signed 32-bit value, then sign-extended.
module riscv_soft_imm_extract
    import riscv_soft_imm_stage_pkg::*;
#(
    parameter int XPR_LEN = 32
) (
    input  logic [31:0]          inst,
    input  logic [IMM_SEL_W-1:0] imm_sel,
    output logic [XPR_LEN-1:0]   imm,
    output logic                 bad_sel
);

    logic signed [31:0] w_imm32;

    // Select the immediate layout; zimm is zero-padded so its
    // sign bit is always 0 and the later sign-extension is harmless.
    always_comb begin
        w_imm32 = '0;
        bad_sel = 1'b0;
        case (imm_sel)
            IMM_I: w_imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_S: w_imm32 = {{20{inst[31]}}, inst[31:25],
                              inst[11:7]};
            IMM_B: w_imm32 = {{19{inst[31]}}, inst[31], inst[7],
                              inst[30:25], inst[11:8], 1'b0};
            IMM_U: w_imm32 = {inst[31:12], 12'b0};
            IMM_J: w_imm32 = {{11{inst[31]}}, inst[31],
                              inst[19:12], inst[20],
                              inst[30:21], 1'b0};
            IMM_Z: w_imm32 = {27'b0, inst[19:15]};
            default: bad_sel = 1'b1;
        endcase
    end

    assign imm = XPR_LEN'(w_imm32);

endmodule

// File: rtl/riscv_soft_imm_stage.sv
// Pipelined immediate stage: extract, add to PC, buffer in a
// 2-entry FIFO with valid/ready on both sides and a flush.
module riscv_soft_imm_stage
    import riscv_soft_imm_stage_pkg::*;
#(
    parameter int XPR_LEN = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_inst,
    input  logic [XPR_LEN-1:0]   in_pc,
    input  logic [IMM_SEL_W-1:0] in_imm_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XPR_LEN-1:0]   out_imm,
    output logic [XPR_LEN-1:0]   out_target,
    output logic                 out_bad_sel
);

    if (!(XPR_LEN == 32 || XPR_LEN == 64)) begin : g_bad_xpr
        $error("riscv_soft_imm_stage: XPR_LEN must be 32 or 64");
    end

    logic [XPR_LEN-1:0] w_imm;
    logic [XPR_LEN-1:0] w_target;
    logic               w_bad;
    logic               w_push;
    logic               w_pop;

    logic [XPR_LEN-1:0] r_imm [2];
    logic [XPR_LEN-1:0] r_tgt [2];
    logic [1:0]         r_bad;
    logic               r_wr;
    logic               r_rd;
    logic [1:0]         r_cnt;
    logic [XPR_LEN-1:0] r_hold_imm;
    logic [XPR_LEN-1:0] r_hold_tgt;
    logic               r_hold_bad;

    riscv_soft_imm_extract #(
        .XPR_LEN (XPR_LEN)
    ) u_extract (
        .inst    (in_inst),
        .imm_sel (in_imm_sel),
        .imm     (w_imm),
        .bad_sel (w_bad)
    );

    assign w_target  = in_pc + w_imm;
    assign in_ready  = (r_cnt != 2'd2);
    assign out_valid = (r_cnt != 2'd0);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready;

    // Head entry while valid; otherwise the last popped entry so the
    // outputs stay put once the FIFO drains.
    assign out_imm     = out_valid ? r_imm[r_rd] : r_hold_imm;
    assign out_target  = out_valid ? r_tgt[r_rd] : r_hold_tgt;
    assign out_bad_sel = out_valid ? r_bad[r_rd] : r_hold_bad;

    // FIFO storage, pointers and occupancy; flush beats push and pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_imm[0]   <= '0;
            r_imm[1]   <= '0;
            r_tgt[0]   <= '0;
            r_tgt[1]   <= '0;
            r_bad      <= '0;
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_cnt      <= 2'd0;
            r_hold_imm <= '0;
            r_hold_tgt <= '0;
            r_hold_bad <= 1'b0;
        end else if (flush) begin
            r_wr  <= 1'b0;
            r_rd  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_imm[r_wr] <= w_imm;
                r_tgt[r_wr] <= w_target;
                r_bad[r_wr] <= w_bad;
                r_wr        <= ~r_wr;
            end
            if (w_pop) begin
                r_hold_imm <= r_imm[r_rd];
                r_hold_tgt <= r_tgt[r_rd];
                r_hold_bad <= r_bad[r_rd];
                r_rd       <= ~r_rd;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_soft_imm_stage.sv
// Directed bench for riscv_soft_imm_stage at XPR_LEN 32 and 64.
// Hand-computed vectors, immediate assertions at each check point.
module tb_riscv_soft_imm_stage;

    logic        clk;
    logic        reset;
    logic        flush;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [2:0]  in_imm_sel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [31:0] out_target;
    logic        out_bad_sel;

    logic        v64;
    logic        rdy64;
    logic [31:0] inst64;
    logic [63:0] pc64;
    logic [2:0]  sel64;
    logic        ov64;
    logic        ordy64;
    logic [63:0] imm64;
    logic [63:0] tgt64;
    logic        bad64;

    int checks = 0;
    int errors = 0;

    riscv_soft_imm_stage #(.XPR_LEN(32)) dut32 (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .in_imm_sel  (in_imm_sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_target  (out_target),
        .out_bad_sel (out_bad_sel)
    );

    riscv_soft_imm_stage #(.XPR_LEN(64)) dut64 (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (v64),
        .in_ready    (rdy64),
        .in_inst     (inst64),
        .in_pc       (pc64),
        .in_imm_sel  (sel64),
        .out_valid   (ov64),
        .out_ready   (ordy64),
        .out_imm     (imm64),
        .out_target  (tgt64),
        .out_bad_sel (bad64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst,
                         input logic [31:0] pc, input logic [2:0] sel);
        in_valid   = v;
        in_inst    = inst;
        in_pc      = pc;
        in_imm_sel = sel;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 3'd0);
        v64    = 1'b0;
        inst64 = 32'h0;
        pc64   = 64'h0;
        sel64  = 3'd0;
        ordy64 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_imm", 64'(out_imm), 64'd0);
        chk("rst_target", 64'(out_target), 64'd0);
        chk("rst_bad", 64'(out_bad_sel), 64'd0);
        chk("rst64_valid", 64'(ov64), 64'd0);

        // I-type, negative immediate
        out_ready = 1'b1;
        drive(1'b1, 32'hFFF00093, 32'h100, 3'd0);
        step();
        drive(1'b0, 32'h0, 32'h0, 3'd0);
        chk("i_valid", 64'(out_valid), 64'd1);
        chk("i_imm", 64'(out_imm), 64'hFFFFFFFF);
        chk("i_target", 64'(out_target), 64'h000000FF);
        chk("i_bad", 64'(out_bad_sel), 64'd0);

        // B-type, target wraps below zero
        step();
        chk("i_drained", 64'(out_valid), 64'd0);
        drive(1'b1, 32'hFE000EE3, 32'h0, 3'd2);
        step();
        drive(1'b0, 32'h0, 32'h0, 3'd0);
        chk("b_valid", 64'(out_valid), 64'd1);
        chk("b_imm", 64'(out_imm), 64'hFFFFFFFC);
        chk("b_target", 64'(out_target), 64'hFFFFFFFC);
        step();

        // backpressure: JAL, ADDI, then SW held off
        out_ready = 1'b0;
        drive(1'b1, 32'h0080006F, 32'h100, 3'd4);
        step();
        chk("bp1_in_ready", 64'(in_ready), 64'd1);
        chk("bp1_imm", 64'(out_imm), 64'd8);
        drive(1'b1, 32'h00500093, 32'h104, 3'd0);
        step();
        chk("bp2_in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 32'h00112223, 32'h200, 3'd1);
        step();
        chk("bp3_in_ready", 64'(in_ready), 64'd0);
        chk("bp3_imm", 64'(out_imm), 64'd8);
        chk("bp3_target", 64'(out_target), 64'h108);
        step();
        chk("bp4_imm", 64'(out_imm), 64'd8);
        chk("bp4_target", 64'(out_target), 64'h108);
        out_ready = 1'b1;
        step();
        chk("dr1_in_ready", 64'(in_ready), 64'd1);
        chk("dr1_imm", 64'(out_imm), 64'd5);
        chk("dr1_target", 64'(out_target), 64'h109);
        step();
        drive(1'b0, 32'h0, 32'h0, 3'd0);
        chk("dr2_valid", 64'(out_valid), 64'd1);
        chk("dr2_imm", 64'(out_imm), 64'd4);
        chk("dr2_target", 64'(out_target), 64'h204);
        step();
        chk("dr3_valid", 64'(out_valid), 64'd0);
        chk("dr3_in_ready", 64'(in_ready), 64'd1);

        // flush with two entries and a live input
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h10, 3'd0);
        step();
        drive(1'b1, 32'h00200093, 32'h20, 3'd0);
        step();
        chk("fl_full", 64'(in_ready), 64'd0);
        flush = 1'b1;
        drive(1'b1, 32'h00300093, 32'h30, 3'd0);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 3'd0);
        chk("fl2_valid", 64'(out_valid), 64'd0);
        chk("fl2_in_ready", 64'(in_ready), 64'd1);

        // flush with one entry: the same-cycle input must be dropped
        drive(1'b1, 32'h00400093, 32'h40, 3'd0);
        step();
        flush = 1'b1;
        drive(1'b1, 32'h00500093, 32'h50, 3'd0);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 3'd0);
        chk("fl1_valid", 64'(out_valid), 64'd0);
        step();
        chk("fl1_not_enq", 64'(out_valid), 64'd0);

        // illegal selects still deliver an entry
        drive(1'b1, 32'h12345678, 32'h40, 3'd7);
        step();
        drive(1'b1, 32'hFFFFFFFF, 32'h80, 3'd6);
        chk("sel7_valid", 64'(out_valid), 64'd1);
        chk("sel7_imm", 64'(out_imm), 64'd0);
        chk("sel7_target", 64'(out_target), 64'h40);
        chk("sel7_bad", 64'(out_bad_sel), 64'd1);
        out_ready = 1'b1;
        step();
        drive(1'b0, 32'h0, 32'h0, 3'd0);
        chk("sel6_imm", 64'(out_imm), 64'd0);
        chk("sel6_target", 64'(out_target), 64'h80);
        chk("sel6_bad", 64'(out_bad_sel), 64'd1);
        step();
        chk("sel_drained", 64'(out_valid), 64'd0);

        // 64-bit: U sign-extends from bit 31, Z zero-extends
        v64    = 1'b1;
        inst64 = 32'h800000B7;
        pc64   = 64'h1000;
        sel64  = 3'd3;
        step();
        inst64 = 32'h000F8000;
        sel64  = 3'd5;
        chk("u64_valid", 64'(ov64), 64'd1);
        chk("u64_imm", imm64, 64'hFFFFFFFF80000000);
        chk("u64_target", tgt64, 64'hFFFFFFFF80001000);
        step();
        v64 = 1'b0;
        chk("z64_imm", imm64, 64'h1F);
        chk("z64_target", tgt64, 64'h101F);
        chk("z64_bad", 64'(bad64), 64'd0);
        step();

        // asynchronous reset mid-stream with one entry buffered
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h10, 3'd0);
        step();
        drive(1'b0, 32'h0, 32'h0, 3'd0);
        chk("ar_pre_valid", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_in_ready", 64'(in_ready), 64'd1);
        #1;
        reset = 1'b0;
        step();
        chk("ar_after_valid", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_soft_imm_stage.md
Name: riscv_soft_imm_stage

Overview:
- Parametrised, pipelined immediate-generation stage between fetch/decode and execute.
- Decodes the immediate for I/S/B/U/J plus CSR zimm (Z), sign- or zero-extended to XPR_LEN (RV32 or RV64).
- Computes the PC-relative target (pc + imm) in the same cycle.
- Results are buffered in a 2-entry FIFO with valid/ready handshakes on both sides and a flush input.

Parameters:
XPR_LEN, 32, datapath width; legal values 32 or 64.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
flush  input  1  drop all buffered entries; ignore same-cycle input
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept an entry
in_inst  input  32  instruction word
in_pc  input  XPR_LEN  PC of in_inst
in_imm_sel  input  3  immediate type select
out_valid  output  1  head entry valid
out_ready  input  1  downstream accepts head
out_imm  output  XPR_LEN  extended immediate
out_target  output  XPR_LEN  in_pc + imm, modulo 2^XPR_LEN
out_bad_sel  output  1  head entry had an unsupported imm_sel

Behaviour:
- Single clock domain on clk. reset is asynchronous and active-high.
- Reset values: FIFO count 0; rd/wr pointers 0; out_valid 0; in_ready 1; out_imm, out_target, out_bad_sel 0.
- Extraction (combinational, at input):
  - I: sext(inst[31:20])
  - S: sext({inst[31:25], inst[11:7]})
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0})
  - U: sext({inst[31:12], 12'b0}); sign-extends from bit 31 when XPR_LEN=64
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0})
  - Z: zext(inst[19:15])
  - Codes 6 and 7: imm = 0 and bad_sel = 1; entry still enqueued.
- target = in_pc + imm, truncated to XPR_LEN, with no overflow flag. Computed for every type, including Z.
- Push when in_valid && in_ready && !flush. Pop when out_valid && out_ready.
- Storage: 2 entries of {imm, target, bad_sel}. Count range 0..2. Pointers are 1 bit and wrap 1→0.
- Latency: an entry pushed in cycle N appears at out_* with out_valid=1 in cycle N+1. No combinational path from in_* to out_*.
- out_valid = (count != 0). out_* show the head entry and must hold stable while out_valid && !out_ready.
- in_ready = (count != 2). It depends on registered state only, with no combinational path from out_ready.
- Simultaneous push and pop with count=1: count stays 1 and order is preserved. With count=2, push is impossible.
- When empty (count=0), out_imm/out_target/out_bad_sel hold their last values (0 after reset). Bench must not check them while out_valid=0.
- flush: next cycle count=0 and pointers=0. Overrides push and pop in the same cycle. Data registers may be left unchanged.
- reset mid-operation: all state is cleared immediately (asynchronously); in-flight entries are lost.
- XPR_LEN outside {32, 64}: elaboration error via generate-time check.

Decomposition:
- Shared header riscv_soft_defines.vh:
  - IMM_I=3'd0, IMM_S=3'd1, IMM_B=3'd2, IMM_U=3'd3, IMM_J=3'd4, IMM_Z=3'd5
  - IMM_SEL_W=3
- One sub-module, riscv_soft_imm_extract: combinational, parameter XPR_LEN; inputs inst and imm_sel; outputs imm and bad_sel.
- The FIFO and adder stay inline in riscv_soft_imm_stage.

Test Plan:
- XPR_LEN=32, pc=0x100, inst=0xFFF00093, sel I, out_ready=1 → next cycle out_valid=1, imm=0xFFFFFFFF, target=0x000000FF, bad_sel=0.
- XPR_LEN=32, pc=0x0, inst=0xFE000EE3, sel B → imm=0xFFFFFFFC, target=0xFFFFFFFC (wrap).
- Backpressure:
  - Stimulus: out_ready=0; push JAL 0x0080006F sel J at pc 0x100, then ADDI sel I, then a third entry.
  - Required: after two pushes in_ready=0 and the third is held off; head stays imm=8, target=0x108.
  - Then raise out_ready: entries drain in order, and in_ready=1 one cycle after the first pop.
- Flush: count=2, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed-cycle input is not enqueued.
- XPR_LEN=64, inst=0x800000B7, sel U, pc=0x1000 → imm=0xFFFFFFFF80000000, target=0xFFFFFFFF80001000. Same width: sel Z with inst[19:15]=5'h1F → imm=0x1F.
- Illegal select and reset:
  - sel=3'd7 → imm=0, bad_sel=1, entry still delivered.
  - Assert reset asynchronously mid-stream with count=1 → out_valid=0 and in_ready=1 before the next clk edge.
